// File: rtl/dm_byte_port.sv
// dm_byte_port: word/byte load-store responder for a 1-cycle synchronous word-only RAM.
// Define DM_ALIGN_CHECK_EN to trap misaligned word requests (adds the err output).
module dm_byte_port #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        byte_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
`ifdef DM_ALIGN_CHECK_EN
    output logic        err,
`endif
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    generate
        if (MEM_LAT != 1) begin : g_lat_check
            $error("dm_byte_port supports MEM_LAT = 1 only");
        end
    endgenerate

    logic [2:0]  state_q,     state_d;
    logic        we_q,        we_d;
    logic        byte_q,      byte_d;
    logic [1:0]  off_q,       off_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] word_q,      word_d;
    logic [31:0] rdata_q,     rdata_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_re_q,    mem_re_d;
    logic        mem_we_q,    mem_we_d;
`ifdef DM_ALIGN_CHECK_EN
    logic        err_q,       err_d;
`endif

    logic [4:0]  laneSel;
    logic [7:0]  capLane;
    logic [31:0] mergedWord;

    // Lane extraction and merge work straight off mem_rdata in CAP, the same value word_q captures.
    always_comb begin
        laneSel    = {off_q, 3'b000};
        capLane    = mem_rdata[laneSel +: 8];
        mergedWord = mem_rdata;
        mergedWord[laneSel +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        byte_d      = byte_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
`ifdef DM_ALIGN_CHECK_EN
                    if (!byte_op && (addr[1:0] != 2'b00)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else
`endif
                    begin
                        we_d       = we;
                        byte_d     = byte_op;
                        off_d      = addr[1:0];
                        wdata_d    = wdata;
                        mem_addr_d = {addr[31:2], 2'b00};
                        if (we && !byte_op) begin
                            state_d     = ST_WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = wdata;
                        end else begin
                            state_d  = ST_RD;
                            mem_re_d = 1'b1;
                        end
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                word_d = mem_rdata;
                if (!we_q) begin
                    state_d = ST_DONE;
                    rdata_d = byte_q ? {24'b0, capLane} : mem_rdata;
                end else begin
                    state_d     = ST_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = mergedWord;
                end
            end
            ST_WR: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= 32'd0;
            word_q      <= 32'd0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
`ifdef DM_ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
`ifdef DM_ALIGN_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
`ifdef DM_ALIGN_CHECK_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_dm_byte_port.sv
// tb_dm_byte_port: randomized self-checking bench for dm_byte_port against a word-array memory model.
// Builds with or without DM_ALIGN_CHECK_EN.
module tb_dm_byte_port;

    logic        clk = 1'b0;
    logic        rst, req, we, byte_op;
    logic [31:0] addr, wdata;
    logic        busy, done, mem_re, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DM_ALIGN_CHECK_EN
    logic        err;
`endif

    always #5 clk = ~clk;

    dm_byte_port #(.MEM_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_op(byte_op),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
`ifdef DM_ALIGN_CHECK_EN
        .err(err),
`endif
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM the DUT drives: one-cycle read latency, 128 words.
    logic [31:0] ram [0:127];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[8:2]] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr[8:2]];
    end

    int compared = 0;
    int mismatched = 0;

    logic [31:0] modelMem [0:127];
    logic [31:0] expRdata;
    int          expLat, expRe, expWe;
    logic        expErr;

    int          obsLat, obsReCnt, obsWeCnt, obsFirstRe, obsFirstWe;
    logic [31:0] obsReAddr, obsWeAddr, obsWeData;
    logic        obsBusyGap, obsBoth, obsErr;

    // Reference behaviour of one request computed from the access rules directly.
    task automatic modelOp(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
        int idx;
        int sh;
        logic [31:0] mask;
        idx = int'(a[8:2]);
        sh = 8 * int'(a[1:0]);
        expErr = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
        if (!b && a[1:0] != 2'b00) begin
            expErr = 1'b1; expLat = 1; expRe = 0; expWe = 0;
            return;
        end
`endif
        if (w && !b) begin
            modelMem[idx] = d; expLat = 2; expRe = 0; expWe = 1;
        end else if (w) begin
            mask = 32'hFF << sh;
            modelMem[idx] = (modelMem[idx] & ~mask) | ((d & 32'hFF) << sh);
            expLat = 4; expRe = 1; expWe = 1;
        end else begin
            expLat = 3; expRe = 1; expWe = 0;
            expRdata = b ? ((modelMem[idx] >> sh) & 32'hFF) : modelMem[idx];
        end
    endtask

    // Issue one request and record what the DUT does cycle by cycle until done (bounded).
    task automatic runOp(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                         input logic toggle);
        @(negedge clk);
        req = 1'b1; we = w; byte_op = b; addr = a; wdata = d;
        obsLat = -1; obsReCnt = 0; obsWeCnt = 0; obsFirstRe = -1; obsFirstWe = -1;
        obsReAddr = '0; obsWeAddr = '0; obsWeData = '0;
        obsBusyGap = 1'b0; obsBoth = 1'b0; obsErr = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 12; c++) begin
            if (mem_re) begin
                obsReCnt++; obsReAddr = mem_addr;
                if (obsFirstRe < 0) obsFirstRe = c;
            end
            if (mem_we) begin
                obsWeCnt++; obsWeAddr = mem_addr; obsWeData = mem_wdata;
                if (obsFirstWe < 0) obsFirstWe = c;
            end
            if (mem_re && mem_we) obsBoth = 1'b1;
            if (!busy) obsBusyGap = 1'b1;
`ifdef DM_ALIGN_CHECK_EN
            if (err) obsErr = 1'b1;
`endif
            if (done) begin
                obsLat = c;
                break;
            end
            if (toggle) begin
                req = 1'(($urandom_range(0, 1)));
                we = 1'($urandom_range(0, 1));
                byte_op = 1'($urandom_range(0, 1));
                addr = 32'($urandom_range(0, 511));
                wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; we = 1'b0; byte_op = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        compared++; if (mem_re !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_re: got %0b expected 0", mem_re); end
        compared++; if (mem_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %0b expected 0", mem_we); end
        compared++; if (rdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        compared++; if (mem_addr !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        compared++; if (mem_wdata !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
`ifdef DM_ALIGN_CHECK_EN
        compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %0b expected 0", err); end
`endif
        rst = 1'b0;
        expRdata = 32'd0;
    endtask

    task automatic test_word_store_load;
        modelOp(1'b1, 1'b0, 32'h100, 32'h1234_5678);
        runOp(1'b1, 1'b0, 32'h100, 32'h1234_5678, 1'b0);
        compared++; if (obsLat != 2) begin mismatched++; $display("[TB] FAIL wst_latency: got %0d expected 2", obsLat); end
        compared++; if (obsFirstWe != 1) begin mismatched++; $display("[TB] FAIL wst_we_cycle: got %0d expected 1", obsFirstWe); end
        compared++; if (obsWeAddr !== 32'h100) begin mismatched++; $display("[TB] FAIL wst_addr: got %h expected 100", obsWeAddr); end
        compared++; if (obsWeData !== 32'h1234_5678) begin mismatched++; $display("[TB] FAIL wst_data: got %h expected 12345678", obsWeData); end
        compared++; if (obsReCnt != 0) begin mismatched++; $display("[TB] FAIL wst_no_read: got %0d reads expected 0", obsReCnt); end
        modelOp(1'b0, 1'b0, 32'h100, 32'h0);
        runOp(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
        compared++; if (obsLat != 3) begin mismatched++; $display("[TB] FAIL wld_latency: got %0d expected 3", obsLat); end
        compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL wld_rdata: got %h expected %h", rdata, expRdata); end
        compared++; if (obsReAddr !== 32'h100) begin mismatched++; $display("[TB] FAIL wld_addr: got %h expected 100", obsReAddr); end
    endtask

    task automatic test_byte_store;
        logic [31:0] keep;
        modelOp(1'b1, 1'b0, 32'h40, 32'h7890_1234);
        runOp(1'b1, 1'b0, 32'h40, 32'h7890_1234, 1'b0);
        keep = expRdata;
        modelOp(1'b1, 1'b1, 32'h41, 32'h1234_5678);
        runOp(1'b1, 1'b1, 32'h41, 32'h1234_5678, 1'b0);
        compared++; if (obsLat != 4) begin mismatched++; $display("[TB] FAIL bst_latency: got %0d expected 4", obsLat); end
        compared++; if (obsFirstRe != 1) begin mismatched++; $display("[TB] FAIL bst_re_cycle: got %0d expected 1", obsFirstRe); end
        compared++; if (obsFirstWe != 3) begin mismatched++; $display("[TB] FAIL bst_we_cycle: got %0d expected 3", obsFirstWe); end
        compared++; if (obsWeData !== modelMem[16]) begin mismatched++; $display("[TB] FAIL bst_merge: got %h expected %h", obsWeData, modelMem[16]); end
        compared++; if (obsBoth !== 1'b0) begin mismatched++; $display("[TB] FAIL bst_strobe_overlap: got %0b expected 0", obsBoth); end
        compared++; if (rdata !== keep) begin mismatched++; $display("[TB] FAIL bst_rdata_held: got %h expected %h", rdata, keep); end
        compared++; if (ram[16] !== modelMem[16]) begin mismatched++; $display("[TB] FAIL bst_ram: got %h expected %h", ram[16], modelMem[16]); end
    endtask

    task automatic test_byte_loads;
        for (int i = 0; i < 4; i++) begin
            modelOp(1'b0, 1'b1, 32'h40 + 32'(i), 32'h0);
            runOp(1'b0, 1'b1, 32'h40 + 32'(i), 32'h0, 1'b0);
            compared++; if (obsLat != 3) begin mismatched++; $display("[TB] FAIL bld_latency lane %0d: got %0d expected 3", i, obsLat); end
            compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL bld_rdata lane %0d: got %h expected %h", i, rdata, expRdata); end
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] d;
        d = $urandom;
        modelOp(1'b1, 1'b1, 32'h42, d);
        runOp(1'b1, 1'b1, 32'h42, d, 1'b1);
        compared++; if (obsLat != 4) begin mismatched++; $display("[TB] FAIL busy_latency: got %0d expected 4", obsLat); end
        compared++; if (obsBusyGap !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_gap: got %0b expected 0", obsBusyGap); end
        compared++; if (obsReCnt != 1 || obsWeCnt != 1) begin mismatched++; $display("[TB] FAIL busy_strobes: got re=%0d we=%0d expected 1/1", obsReCnt, obsWeCnt); end
        compared++; if (obsWeAddr !== 32'h40) begin mismatched++; $display("[TB] FAIL busy_addr: got %h expected 40", obsWeAddr); end
        compared++; if (ram[16] !== modelMem[16]) begin mismatched++; $display("[TB] FAIL busy_ram: got %h expected %h", ram[16], modelMem[16]); end
        @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_reset_midop;
        logic sawBad;
        @(negedge clk);
        req = 1'b1; we = 1'b1; byte_op = 1'b1; addr = 32'h41; wdata = 32'h0000_00AB;
        @(negedge clk);
        req = 1'b0;
        compared++; if (mem_re !== 1'b1) begin mismatched++; $display("[TB] FAIL rstmid_rd: got %0b expected 1", mem_re); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++; if (busy !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0) begin
            mismatched++; $display("[TB] FAIL rstmid_idle: got busy=%0b we=%0b done=%0b expected 0/0/0", busy, mem_we, done);
        end
        sawBad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (done || mem_we || busy) sawBad = 1'b1;
            @(negedge clk);
        end
        compared++; if (sawBad !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_quiet: got activity=%0b expected 0", sawBad); end
        compared++; if (ram[16] !== modelMem[16]) begin mismatched++; $display("[TB] FAIL rstmid_ram: got %h expected %h", ram[16], modelMem[16]); end
        compared++; if (rdata !== 32'd0) begin mismatched++; $display("[TB] FAIL rstmid_rdata: got %h expected 0", rdata); end
        expRdata = 32'd0;
    endtask

    task automatic test_back_to_back;
        int d1, d2;
        modelOp(1'b0, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        req = 1'b1; we = 1'b0; byte_op = 1'b0; addr = 32'h100; wdata = 32'h0;
        d1 = -1; d2 = -1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) d1 = c;
                else begin d2 = c; break; end
            end
        end
        req = 1'b0;
        compared++; if (d1 != 3 || d2 != 7) begin mismatched++; $display("[TB] FAIL b2b_done_cycles: got %0d,%0d expected 3,7", d1, d2); end
        compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL b2b_rdata: got %h expected %h", rdata, expRdata); end
    endtask

    task automatic test_align;
        logic [31:0] keep;
        keep = expRdata;
        modelOp(1'b0, 1'b0, 32'h102, 32'h0);
        runOp(1'b0, 1'b0, 32'h102, 32'h0, 1'b0);
        compared++; if (obsLat != expLat) begin mismatched++; $display("[TB] FAIL align_latency: got %0d expected %0d", obsLat, expLat); end
        compared++; if (obsReCnt != expRe) begin mismatched++; $display("[TB] FAIL align_reads: got %0d expected %0d", obsReCnt, expRe); end
        compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL align_rdata: got %h expected %h (prev %h)", rdata, expRdata, keep); end
`ifdef DM_ALIGN_CHECK_EN
        compared++; if (obsErr !== expErr) begin mismatched++; $display("[TB] FAIL align_err: got %0b expected %0b", obsErr, expErr); end
`endif
    endtask

    task automatic test_random;
        logic        w, b;
        logic [31:0] a, d;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            modelOp(1'b1, 1'b0, 32'h80 + 32'(4 * i), d);
            runOp(1'b1, 1'b0, 32'h80 + 32'(4 * i), d, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            a = 32'h80 + 32'($urandom_range(0, 63));
            d = $urandom;
            modelOp(w, b, a, d);
            runOp(w, b, a, d, 1'($urandom_range(0, 1)));
            compared++; if (obsLat != expLat) begin mismatched++; $display("[TB] FAIL rand_latency #%0d: got %0d expected %0d", i, obsLat, expLat); end
            compared++; if (rdata !== expRdata) begin mismatched++; $display("[TB] FAIL rand_rdata #%0d: got %h expected %h", i, rdata, expRdata); end
            compared++; if (obsReCnt != expRe || obsWeCnt != expWe) begin
                mismatched++; $display("[TB] FAIL rand_strobes #%0d: got re=%0d we=%0d expected %0d/%0d", i, obsReCnt, obsWeCnt, expRe, expWe);
            end
`ifdef DM_ALIGN_CHECK_EN
            compared++; if (obsErr !== expErr) begin mismatched++; $display("[TB] FAIL rand_err #%0d: got %0b expected %0b", i, obsErr, expErr); end
`endif
        end
        for (int i = 32; i < 48; i++) begin
            compared++; if (ram[i] !== modelMem[i]) begin mismatched++; $display("[TB] FAIL rand_ram word %0d: got %h expected %h", i, ram[i], modelMem[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_word_store_load;
        test_byte_store;
        test_byte_loads;
        test_busy_ignore;
        test_reset_midop;
        test_back_to_back;
        test_align;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
